exec_sequencer: RTL and testbench

//  Fetch/execute stage directly downstream of the program counter + ROM (CPU mode 1).
//  - Latches the 8-bit instruction word: [7:5] opcode, [4:0] operand.
//  - Executes the instruction against an 8-bit accumulator.
//  - Pulses pc_ena for one cycle per retired instruction, so the PC advances exactly once per instruction.

---
 rtl/exec_pkg.sv | 23 ++
 rtl/exec_mul_iter.sv | 53 +++++
 rtl/exec_sequencer.sv | 167 ++++++++++++++++
 tb/tb_exec_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared opcodes, FSM state encodings and default widths for the exec stage.
package exec_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OPND_W_DEF = 5;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_LDI  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_MULW  = 2'b11
  } state_t;

endpackage

// File: rtl/exec_mul_iter.sv
// Shift-add multiplier, one multiplier bit per cycle, LSB first.
// done marks the cycle whose closing edge finishes the last iteration; product is valid then.
module exec_mul_iter
  import exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OPND_W = OPND_W_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [DATA_W-1:0]          a,
  input  logic [OPND_W-1:0]          b,
  output logic                       done,
  output logic [DATA_W+OPND_W-1:0]   product
);

  localparam int PW = DATA_W + OPND_W;
  localparam int CW = $clog2(OPND_W + 1);

  logic [PW-1:0]     r_mcand;
  logic [OPND_W-1:0] r_mplier;
  logic [PW-1:0]     r_prod;
  logic [CW-1:0]     r_cnt;
  logic [PW-1:0]     w_addend;
  logic [PW-1:0]     w_prod_nxt;

  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_prod_nxt = r_prod + w_addend;
  assign done       = (r_cnt == CW'(1));
  // Product is exposed one step early so the caller can write it on the final edge.
  assign product    = w_prod_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else if (start) begin
      r_mcand  <= {{OPND_W{1'b0}}, a};
      r_mplier <= b;
      r_prod   <= '0;
      r_cnt    <= CW'(OPND_W);
    end else if (r_cnt != '0) begin
      r_prod   <= w_prod_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/exec_sequencer.sv
// Fetch/execute stage behind the PC/ROM: latches an instruction, runs it on the accumulator.
// Build option EXEC_ITER_MUL_EN selects the multi-cycle MUL (MULW state) via exec_mul_iter.
module exec_sequencer
  import exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OPND_W = OPND_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [7:0]        instr_in,
  output logic              pc_ena,
  output logic [DATA_W-1:0] acc_out,
  output logic              carry_out,
  output logic              zero_out,
  output logic              busy,
  output logic              halted,
  output logic [1:0]        state_out
);

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_ir, w_ir_nxt;
  logic [DATA_W-1:0] r_acc, w_acc_nxt;
  logic              r_carry, w_carry_nxt;
  logic              r_zero, w_zero_nxt;
  logic              r_halted, w_halted_nxt;
  logic              r_pc_ena, w_pc_ena_nxt;
  logic              w_write;

  logic [2:0]        w_op;
  logic [DATA_W-1:0] w_opnd;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_c;

  assign w_op   = r_ir[7:5];
  assign w_opnd = {{(DATA_W-OPND_W){1'b0}}, r_ir[OPND_W-1:0]};
  assign w_sum  = {1'b0, r_acc} + {1'b0, w_opnd};
  assign w_diff = {1'b0, r_acc} - {1'b0, w_opnd};

`ifdef EXEC_ITER_MUL_EN
  logic                     w_mul_start;
  logic                     w_mul_done;
  logic [DATA_W+OPND_W-1:0] w_mul_prod;

  exec_mul_iter #(.DATA_W(DATA_W), .OPND_W(OPND_W)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (w_mul_start),
    .a       (r_acc),
    .b       (r_ir[OPND_W-1:0]),
    .done    (w_mul_done),
    .product (w_mul_prod)
  );
`else
  logic [2*DATA_W-1:0] w_mul_full;
  assign w_mul_full = {{DATA_W{1'b0}}, r_acc} * {{DATA_W{1'b0}}, w_opnd};
`endif

  always_comb begin
    w_alu_res = r_acc;
    w_alu_c   = 1'b0;
    case (w_op)
      OP_ADD: {w_alu_c, w_alu_res} = w_sum;
      OP_SUB: {w_alu_c, w_alu_res} = w_diff;
      OP_MUL: begin
`ifdef EXEC_ITER_MUL_EN
        w_alu_res = w_mul_prod[DATA_W-1:0];
        w_alu_c   = |w_mul_prod[DATA_W+OPND_W-1:DATA_W];
`else
        w_alu_res = w_mul_full[DATA_W-1:0];
        w_alu_c   = |w_mul_full[2*DATA_W-1:DATA_W];
`endif
      end
      OP_AND: w_alu_res = r_acc & w_opnd;
      OP_OR:  w_alu_res = r_acc | w_opnd;
      OP_XOR: w_alu_res = r_acc ^ w_opnd;
      OP_LDI: w_alu_res = w_opnd;
      default: w_alu_res = r_acc;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ir_nxt     = r_ir;
    w_acc_nxt    = r_acc;
    w_carry_nxt  = r_carry;
    w_zero_nxt   = r_zero;
    w_halted_nxt = r_halted;
    w_pc_ena_nxt = 1'b0;
    w_write      = 1'b0;
`ifdef EXEC_ITER_MUL_EN
    w_mul_start  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: if (run && !r_halted) w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (run) begin
          w_ir_nxt    = instr_in;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (w_op == OP_HALT) begin
          w_halted_nxt = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
`ifdef EXEC_ITER_MUL_EN
        else if (w_op == OP_MUL) begin
          w_mul_start = 1'b1;
          w_state_nxt = ST_MULW;
        end
`endif
        else begin
          w_write = 1'b1;
        end
      end
      ST_MULW: begin
`ifdef EXEC_ITER_MUL_EN
        if (w_mul_done) w_write = 1'b1;
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Retire: acc/flags and the PC strobe all land on the same edge.
    if (w_write) begin
      w_acc_nxt    = w_alu_res;
      w_carry_nxt  = w_alu_c;
      w_zero_nxt   = (w_alu_res == '0);
      w_pc_ena_nxt = 1'b1;
      w_state_nxt  = ST_FETCH;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_ir     <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b1;
      r_halted <= 1'b0;
      r_pc_ena <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ir     <= w_ir_nxt;
      r_acc    <= w_acc_nxt;
      r_carry  <= w_carry_nxt;
      r_zero   <= w_zero_nxt;
      r_halted <= w_halted_nxt;
      r_pc_ena <= w_pc_ena_nxt;
    end
  end

  assign pc_ena    = r_pc_ena;
  assign acc_out   = r_acc;
  assign carry_out = r_carry;
  assign zero_out  = r_zero;
  assign busy      = (r_state == ST_EXEC) || (r_state == ST_MULW);
  assign halted    = r_halted;
  assign state_out = r_state;

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer with a 4-word ROM and PC model in front of it.
module tb_exec_sequencer;

`ifdef EXEC_ITER_MUL_EN
  localparam int MUL_GAP  = 7;
  localparam int MULW_CYC = 5;
`else
  localparam int MUL_GAP  = 2;
  localparam int MULW_CYC = 0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] instr_in;
  logic       pc_ena;
  logic [7:0] acc_out;
  logic       carry_out;
  logic       zero_out;
  logic       busy;
  logic       halted;
  logic [1:0] state_out;

  logic [7:0] rom [4];
  logic [1:0] pc;
  logic [1:0] rd_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ret    = 0;
  int n_mulw   = 0;
  int cyc      = 0;
  logic [9:0] exp_q [$];
  int         ret_times [$];

  exec_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .instr_in  (instr_in),
    .pc_ena    (pc_ena),
    .acc_out   (acc_out),
    .carry_out (carry_out),
    .zero_out  (zero_out),
    .busy      (busy),
    .halted    (halted),
    .state_out (state_out)
  );

  always #5 clock = ~clock;

  // PC advances on pc_ena; the ROM sees the incremented address in the strobe cycle.
  always @(posedge clock or posedge reset) begin
    if (reset) pc <= 2'd0;
    else if (pc_ena) pc <= pc + 2'd1;
  end
  assign rd_addr  = pc + {1'b0, pc_ena};
  assign instr_in = rom[rd_addr];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    logic [9:0] e;
    if (!reset && pc_ena) begin
      n_ret = n_ret + 1;
      ret_times.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_pc_ena", {31'd0, pc_ena}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("retire%0d {acc,c,z}", n_ret), {22'd0, acc_out, carry_out, zero_out}, {22'd0, e});
      end
    end
    if (state_out == 2'b11) n_mulw = n_mulw + 1;
  end

  task automatic push(input logic [7:0] acc, input logic c, input logic z);
    exp_q.push_back({acc, c, z});
  endtask

  task automatic load(input logic [7:0] i0, input logic [7:0] i1, input logic [7:0] i2, input logic [7:0] i3);
    rom[0] = i0; rom[1] = i1; rom[2] = i2; rom[3] = i3;
  endtask

  task automatic do_reset();
    @(negedge clock);
    run   = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("leftover_expect", exp_q.size(), 0);
    exp_q.delete();
    ret_times.delete();
    n_ret  = 0;
    n_mulw = 0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_retires(input int target, input int maxcyc);
    int c = 0;
    while (n_ret < target && c < maxcyc) begin
      @(negedge clock);
      #1;
      c++;
    end
    check($sformatf("retire_count_%0d", target), n_ret, target);
  endtask

  task automatic wait_state(input logic [1:0] s, input int maxcyc);
    int c = 0;
    while (state_out !== s && c < maxcyc) begin
      @(negedge clock);
      #1;
      c++;
    end
    check("reach_state", state_out, s);
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    load(8'h00, 8'h00, 8'h00, 8'h00);
    do_reset();
    #1;
    check("rst_pc_ena", pc_ena, 0);
    check("rst_acc", acc_out, 0);
    check("rst_carry", carry_out, 0);
    check("rst_zero", zero_out, 1);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_state", state_out, 0);

    // ADD 3, SUB 2, MUL 5, NOP (ADD 0), two passes
    load(8'h03, 8'h22, 8'h45, 8'h00);
    push(8'd3, 0, 0);  push(8'd1, 0, 0);  push(8'd5, 0, 0);  push(8'd5, 0, 0);
    push(8'd8, 0, 0);  push(8'd6, 0, 0);  push(8'd30, 0, 0); push(8'd30, 0, 0);
    run = 1'b1;
    wait_retires(8, 200);
    run = 1'b0;
    check("prog1_span", ret_times[7] - ret_times[0], 10 + 2 * MUL_GAP);
    repeat (5) @(negedge clock);
    check("prog1_no_extra", n_ret, 8);

    // LDI 31, MUL 31, then HALT
    do_reset();
    load(8'hDF, 8'h5F, 8'hE0, 8'hE0);
    push(8'h1F, 0, 0); push(8'hC1, 1, 0);
    run = 1'b1;
    wait_retires(2, 100);
    check("mul_gap", ret_times[1] - ret_times[0], MUL_GAP);
    begin
      int c = 0;
      while (!halted && c < 50) begin @(negedge clock); #1; c++; end
    end
    check("mulw_cycles", n_mulw, MULW_CYC);
    check("halt_halted", halted, 1);
    check("halt_state", state_out, 0);
    check("halt_acc", acc_out, 8'hC1);
    check("halt_carry", carry_out, 1);
    check("halt_zero", zero_out, 0);
    repeat (20) @(negedge clock);
    check("halt_no_pc_ena", n_ret, 2);
    check("halt_stays_idle", state_out, 0);
    do_reset();
    #1;
    check("reset_clears_halted", halted, 0);

    // LDI 2, SUB 3 (borrow), LDI 0, ADD 0
    load(8'hC2, 8'h23, 8'hC0, 8'h00);
    push(8'd2, 0, 0); push(8'hFF, 1, 0); push(8'd0, 0, 1); push(8'd0, 0, 1);
    run = 1'b1;
    wait_retires(4, 100);
    run = 1'b0;

    // LDI 12, AND 10, OR 5, XOR 13
    do_reset();
    load(8'hCC, 8'h6A, 8'h85, 8'hAD);
    push(8'd12, 0, 0); push(8'd8, 0, 0); push(8'd13, 0, 0); push(8'd0, 0, 1);
    run = 1'b1;
    wait_retires(4, 100);
    run = 1'b0;

    // drop run while the first instruction is in EXEC
    do_reset();
    load(8'h03, 8'h22, 8'h45, 8'h00);
    push(8'd3, 0, 0);
    run = 1'b1;
    wait_state(2'b10, 20);
    run = 1'b0;
    repeat (10) @(negedge clock);
    #1;
    check("hold_one_retire", n_ret, 1);
    check("hold_state_fetch", state_out, 1);
    check("hold_pc_ena_low", pc_ena, 0);
    push(8'd1, 0, 0);
    run = 1'b1;
    wait_retires(2, 50);
    run = 1'b0;
    check("resume_acc", acc_out, 8'd1);

    // asynchronous reset in the middle of MUL
    do_reset();
    load(8'hDF, 8'h5F, 8'hE0, 8'hE0);
    push(8'h1F, 0, 0);
    run = 1'b1;
    wait_retires(1, 50);
`ifdef EXEC_ITER_MUL_EN
    wait_state(2'b11, 20);
    @(negedge clock);
`else
    wait_state(2'b10, 20);
`endif
    check("mid_mul_busy", busy, 1);
    check("mid_mul_acc", acc_out, 8'h1F);
    #2;
    reset = 1'b1;
    #1;
    check("async_acc", acc_out, 0);
    check("async_zero", zero_out, 1);
    check("async_state", state_out, 0);
    check("async_pc_ena", pc_ena, 0);
    check("async_busy", busy, 0);
    run = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("after_async_idle", state_out, 0);
    check("after_async_no_retire", n_ret, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
